// File: rtl/spi_reg_responder.sv
// spi_reg_responder: SPI mode-0 target with a small byte-wide register file.
// Frame is 16 bits MSB first: R/nW, 7-bit address, 8-bit data.
// Every SPI input is brought into the sysclk domain through a 2-flop synchroniser.
// Optional feature macro: SPI_RESP_ERRCNT_EN adds a saturating abort counter at 0x04.
// Handshake: wr_strobe is a one-cycle pulse; wr_addr/wr_data are valid in that
// same cycle and hold until the next committed write.
module spi_reg_responder #(
    parameter logic [7:0] ID_VALUE   = 8'hA5,
    parameter logic [7:0] CTRL_RESET = 8'h00
) (
    input  logic       sysclk,
    input  logic       reset_INV,
    input  logic       spi_clk,
    input  logic       spi_mosi,
    input  logic       spi_cs_INV,
    output logic       spi_miso,
    input  logic [7:0] status_in,
    output logic [7:0] ctrl_out,
    output logic       wr_strobe,
    output logic [6:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_active
);

    logic       sclk_s1_q, sclk_s2_q, sclk_prev_q;
    logic       cs_s1_q, cs_s2_q, cs_prev_q;
    logic       mosi_s1_q, mosi_s2_q;

    logic       armed_q, armed_d;
    logic [1:0] settle_q, settle_d;
    logic [4:0] bit_cnt_q, bit_cnt_d;
    logic [14:0] rx_q, rx_d;
    logic [7:0] tx_q, tx_d;
    logic       miso_q, miso_d;
    logic [7:0] ctrl_q, ctrl_d;
    logic [7:0] scratch_q, scratch_d;
    logic       strobe_q, strobe_d;
    logic [6:0] waddr_q, waddr_d;
    logic [7:0] wdata_q, wdata_d;

    logic       sclk_rise, sclk_fall, frame_en;
    logic [6:0] rd_addr, wr_tgt;
    logic [7:0] rd_value, wr_val;

`ifdef SPI_RESP_ERRCNT_EN
    logic [7:0] errcnt_q, errcnt_d;
    logic       abort;
`endif

    // Synchronisers and previous-value flops for edge detection; reset to idle bus.
    always_ff @(posedge sysclk) begin
        if (!reset_INV) begin
            sclk_s1_q   <= 1'b0;
            sclk_s2_q   <= 1'b0;
            sclk_prev_q <= 1'b0;
            cs_s1_q     <= 1'b1;
            cs_s2_q     <= 1'b1;
            cs_prev_q   <= 1'b1;
            mosi_s1_q   <= 1'b0;
            mosi_s2_q   <= 1'b0;
        end else begin
            sclk_s1_q   <= spi_clk;
            sclk_s2_q   <= sclk_s1_q;
            sclk_prev_q <= sclk_s2_q;
            cs_s1_q     <= spi_cs_INV;
            cs_s2_q     <= cs_s1_q;
            cs_prev_q   <= cs_s2_q;
            mosi_s1_q   <= spi_mosi;
            mosi_s2_q   <= mosi_s1_q;
        end
    end

    assign sclk_rise = sclk_s2_q & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s2_q & sclk_prev_q;
    // Frames are only accepted once chip select has been seen high after reset.
    assign frame_en  = armed_q & ~cs_s2_q;
    // Address is complete when the 8th bit arrives: 6 bits held plus the live MOSI bit.
    assign rd_addr   = {rx_q[5:0], mosi_s2_q};
    // Write target/data are complete when the 16th bit arrives.
    assign wr_tgt    = rx_q[13:7];
    assign wr_val    = {rx_q[6:0], mosi_s2_q};

    // Read multiplexer for the register map; unmapped addresses read zero.
    always_comb begin
        rd_value = 8'h00;
        case (rd_addr)
            7'h00:   rd_value = ID_VALUE;
            7'h01:   rd_value = status_in;
            7'h02:   rd_value = ctrl_q;
            7'h03:   rd_value = scratch_q;
`ifdef SPI_RESP_ERRCNT_EN
            7'h04:   rd_value = errcnt_q;
`endif
            default: rd_value = 8'h00;
        endcase
    end

`ifdef SPI_RESP_ERRCNT_EN
    // A frame exists from its first rising edge; chip select rising before the 16th aborts it.
    assign abort = armed_q & cs_s2_q & ~cs_prev_q & (bit_cnt_q != 5'd0) & (bit_cnt_q < 5'd16);
`endif

    // Frame sequencing: bit counting, shift registers, MISO drive and write commit.
    always_comb begin
        armed_d   = armed_q;
        settle_d  = settle_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        miso_d    = miso_q;
        ctrl_d    = ctrl_q;
        scratch_d = scratch_q;
        strobe_d  = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
`ifdef SPI_RESP_ERRCNT_EN
        errcnt_d  = errcnt_q;
        if (abort && errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
`endif
        // Wait two cycles after reset so the synchronised CS reflects the pin.
        if (settle_q != 2'd2) settle_d = settle_q + 2'd1;
        if (settle_q == 2'd2 && cs_s2_q) armed_d = 1'b1;

        if (!frame_en) begin
            bit_cnt_d = 5'd0;
            rx_d      = 15'd0;
            tx_d      = 8'd0;
            miso_d    = 1'b0;
        end else begin
            if (sclk_rise && bit_cnt_q < 5'd16) begin
                rx_d      = {rx_q[13:0], mosi_s2_q};
                bit_cnt_d = bit_cnt_q + 5'd1;
                if (bit_cnt_q == 5'd7) tx_d = rx_q[6] ? rd_value : 8'h00;
                if (bit_cnt_q == 5'd15 && !rx_q[14]) begin
                    case (wr_tgt)
                        7'h02: begin ctrl_d = wr_val; strobe_d = 1'b1; end
                        7'h03: begin scratch_d = wr_val; strobe_d = 1'b1; end
`ifdef SPI_RESP_ERRCNT_EN
                        7'h04: begin errcnt_d = 8'h00; strobe_d = 1'b1; end
`endif
                        default: strobe_d = 1'b0;
                    endcase
                    if (strobe_d) begin
                        waddr_d = wr_tgt;
                        wdata_d = wr_val;
                    end
                end
            end
            if (sclk_fall) begin
                if (bit_cnt_q >= 5'd8 && bit_cnt_q <= 5'd15) begin
                    miso_d = tx_q[7];
                    tx_d   = {tx_q[6:0], 1'b0};
                end else begin
                    miso_d = 1'b0;
                end
            end
        end
    end

    // Frame state and register file.
    always_ff @(posedge sysclk) begin
        if (!reset_INV) begin
            armed_q   <= 1'b0;
            settle_q  <= 2'd0;
            bit_cnt_q <= 5'd0;
            rx_q      <= 15'd0;
            tx_q      <= 8'd0;
            miso_q    <= 1'b0;
            ctrl_q    <= CTRL_RESET;
            scratch_q <= 8'h00;
            strobe_q  <= 1'b0;
            waddr_q   <= 7'h00;
            wdata_q   <= 8'h00;
`ifdef SPI_RESP_ERRCNT_EN
            errcnt_q  <= 8'h00;
`endif
        end else begin
            armed_q   <= armed_d;
            settle_q  <= settle_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            miso_q    <= miso_d;
            ctrl_q    <= ctrl_d;
            scratch_q <= scratch_d;
            strobe_q  <= strobe_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
`ifdef SPI_RESP_ERRCNT_EN
            errcnt_q  <= errcnt_d;
`endif
        end
    end

    assign spi_miso     = miso_q;
    assign ctrl_out     = ctrl_q;
    assign wr_strobe    = strobe_q;
    assign wr_addr      = waddr_q;
    assign wr_data      = wdata_q;
    assign frame_active = ~cs_s2_q;

endmodule
